// File: rtl/kbd_pkg.sv
// Shared FSM encoding and set-2 prefix constants for the PS/2 scan controller.
package kbd_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPop,
        StGap
    } state_e;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

endpackage

// File: rtl/kbd_ascii_rom.sv
// Set-2 scan code to lowercase ASCII lookup: letters, digits, space, enter; else 0x00.
module kbd_ascii_rom (
    input  logic [7:0] code,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = 8'h00;
        case (code)
            8'h1C: ascii = "a";
            8'h32: ascii = "b";
            8'h21: ascii = "c";
            8'h23: ascii = "d";
            8'h24: ascii = "e";
            8'h2B: ascii = "f";
            8'h34: ascii = "g";
            8'h33: ascii = "h";
            8'h43: ascii = "i";
            8'h3B: ascii = "j";
            8'h42: ascii = "k";
            8'h4B: ascii = "l";
            8'h3A: ascii = "m";
            8'h31: ascii = "n";
            8'h44: ascii = "o";
            8'h4D: ascii = "p";
            8'h15: ascii = "q";
            8'h2D: ascii = "r";
            8'h1B: ascii = "s";
            8'h2C: ascii = "t";
            8'h3C: ascii = "u";
            8'h2A: ascii = "v";
            8'h1D: ascii = "w";
            8'h22: ascii = "x";
            8'h35: ascii = "y";
            8'h1A: ascii = "z";
            8'h45: ascii = "0";
            8'h16: ascii = "1";
            8'h1E: ascii = "2";
            8'h26: ascii = "3";
            8'h25: ascii = "4";
            8'h2E: ascii = "5";
            8'h36: ascii = "6";
            8'h3D: ascii = "7";
            8'h3E: ascii = "8";
            8'h46: ascii = "9";
            8'h29: ascii = 8'h20;
            8'h5A: ascii = 8'h0D;
            default: ascii = 8'h00;
        endcase
    end

endmodule

// File: rtl/kbd_scan_ctrl.sv
// PS/2 receiver FIFO sequencer and set-2 make/break decoder with press counting.
// Define KBD_SCAN_ASCII_EN to add the registered ascii output.
module kbd_scan_ctrl
    import kbd_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned COUNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ready,
    input  logic [7:0]         data,
    input  logic               overflow,
    output logic               nextdata_n,
    output logic [7:0]         cur_code,
    output logic               ext_key,
    output logic               held,
    output logic [COUNT_W-1:0] key_count,
    output logic               ovf_seen,
`ifdef KBD_SCAN_ASCII_EN
    output logic [7:0]         ascii,
`endif
    output logic               byte_stb
);

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_e             state_q, state_d;
    logic [3:0]         gap_q, gap_d;
    logic [7:0]         byte_q, byte_d;
    logic               brk_q, brk_d;
    logic               extp_q, extp_d;
    logic [7:0]         cur_q, cur_d;
    logic               ext_q, ext_d;
    logic               held_q, held_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               nd_q, stb_q, ovf_q;

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        byte_d  = byte_q;
        unique case (state_q)
            StIdle: begin
                if (ready) begin
                    byte_d  = data;
                    state_d = StPop;
                end
            end
            StPop: begin
                gap_d   = '0;
                state_d = StGap;
            end
            StGap: begin
                if (gap_q == GAP_LAST) state_d = StIdle;
                else                   gap_d   = gap_q + 4'd1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        brk_d  = brk_q;
        extp_d = extp_q;
        cur_d  = cur_q;
        ext_d  = ext_q;
        held_d = held_q;
        cnt_d  = cnt_q;
        if (state_q == StPop) begin
            if (byte_q == SC_EXT) begin
                extp_d = 1'b1;
            end else if (byte_q == SC_BRK) begin
                brk_d = 1'b1;
            end else if (brk_q) begin
                // Release only counts if it names exactly the tracked key.
                if (held_q && byte_q == cur_q && extp_q == ext_q) held_d = 1'b0;
                brk_d  = 1'b0;
                extp_d = 1'b0;
            end else begin
                if (!held_q || byte_q != cur_q || extp_q != ext_q) begin
                    cur_d  = byte_q;
                    ext_d  = extp_q;
                    held_d = 1'b1;
                    cnt_d  = cnt_q + COUNT_W'(1);
                end
                extp_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            gap_q   <= '0;
            byte_q  <= '0;
            brk_q   <= 1'b0;
            extp_q  <= 1'b0;
            cur_q   <= '0;
            ext_q   <= 1'b0;
            held_q  <= 1'b0;
            cnt_q   <= '0;
            nd_q    <= 1'b1;
            stb_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            byte_q  <= byte_d;
            brk_q   <= brk_d;
            extp_q  <= extp_d;
            cur_q   <= cur_d;
            ext_q   <= ext_d;
            held_q  <= held_d;
            cnt_q   <= cnt_d;
            // Strobes are registered so they line up exactly with the POP state.
            nd_q    <= (state_d != StPop);
            stb_q   <= (state_d == StPop);
            ovf_q   <= ovf_q | overflow;
        end
    end

    assign nextdata_n = nd_q;
    assign byte_stb   = stb_q;
    assign cur_code   = cur_q;
    assign ext_key    = ext_q;
    assign held       = held_q;
    assign key_count  = cnt_q;
    assign ovf_seen   = ovf_q;

`ifdef KBD_SCAN_ASCII_EN
    logic       press_q;
    logic [7:0] rom_ascii;
    logic [7:0] ascii_q;

    kbd_ascii_rom u_rom (
        .code  (cur_q),
        .ascii (rom_ascii)
    );

    // The counter steps only on a new press, so its change marks one.
    always_ff @(posedge clk) begin
        if (rst) begin
            press_q <= 1'b0;
            ascii_q <= 8'h00;
        end else begin
            press_q <= (cnt_d != cnt_q);
            if (held_q && !held_d) ascii_q <= 8'h00;
            else if (press_q)      ascii_q <= ext_q ? 8'h00 : rom_ascii;
        end
    end

    assign ascii = ascii_q;
`endif

endmodule
